// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared instruction/data memory port between instruction fetch and the
// load/store unit: round-robin on contention, one registered transaction at a time, watchdog abort.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 64,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = 16'hBF00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_load_request,
  input  logic [ADDR_WIDTH-1:0] if_address,
  output logic                  if_output_valid,
  output logic [DATA_WIDTH-1:0] if_instruction,
  input  logic                  ls_request,
  input  logic                  ls_write_enable,
  input  logic [ADDR_WIDTH-1:0] ls_address,
  input  logic [DATA_WIDTH-1:0] ls_write_data,
  output logic                  ls_output_valid,
  output logic [DATA_WIDTH-1:0] ls_read_data,
  output logic                  mem_request,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  mem_output_valid,
  output logic                  busy,
  output logic                  timeout_error
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TO_LAST);
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SERVE_IF = 2'd1,
    S_SERVE_LS = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_last_ls;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_we;
  logic                  r_timeout;

  logic w_serve_if;
  logic w_serve_ls;
  logic w_serving;
  logic w_grant_if;
  logic w_grant_ls;
  logic w_wd_fire;

  assign w_serve_if = (r_state == S_SERVE_IF);
  assign w_serve_ls = (r_state == S_SERVE_LS);
  assign w_serving  = w_serve_if | w_serve_ls;

  // On a tie, the requester that was not served last wins.
  assign w_grant_if = if_load_request & (~ls_request | r_last_ls);
  assign w_grant_ls = ls_request & ~w_grant_if;
  assign w_wd_fire  = WD_EN & (r_cnt == TO_LAST_C);

  // Memory side only ever sees the captured request, never the live requester inputs.
  assign mem_request      = w_serving;
  assign busy             = w_serving;
  assign mem_write_enable = w_serve_ls & r_we;
  assign mem_address      = w_serving ? r_addr : '0;
  assign mem_write_data   = w_serving ? r_wdata : '0;
  assign timeout_error    = r_timeout;

  assign if_output_valid = w_serve_if & mem_output_valid;
  assign if_instruction  = if_output_valid ? mem_read_data : NOP_WORD;
  assign ls_output_valid = w_serve_ls & mem_output_valid;
  assign ls_read_data    = (ls_output_valid & ~r_we) ? mem_read_data : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_last_ls <= 1'b1;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_grant_if) begin
            r_state <= S_SERVE_IF;
            r_addr  <= if_address;
            r_wdata <= '0;
            r_we    <= 1'b0;
          end else if (w_grant_ls) begin
            r_state <= S_SERVE_LS;
            r_addr  <= ls_address;
            r_wdata <= ls_write_data;
            r_we    <= ls_write_enable;
          end
        end
        S_SERVE_IF, S_SERVE_LS: begin
          // A response arriving in the timeout cycle still completes the transaction.
          if (mem_output_valid || w_wd_fire) begin
            r_state   <= S_IDLE;
            r_last_ls <= w_serve_ls;
            r_cnt     <= '0;
            if (!mem_output_valid) r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_last_ls <= 1'b1;
          r_cnt     <= '0;
          r_addr    <= '0;
          r_wdata   <= '0;
          r_we      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single instruction/data memory port between the instruction fetch stage (read-only) and the load/store unit (read/write).
- Sits between both requesters and the memory macro.
- Registers the granted request, holds it stable until the memory returns mem_output_valid, and routes the response back to the owner.
- Round-robin on contention; watchdog on non-responding memory.

Parameters:
ADDR_WIDTH, 12, halfword address width on all address ports
DATA_WIDTH, 16, memory data width
TIMEOUT_CYCLES, 64, cycles in a serve state without mem_output_valid before abort; 0 disables the watchdog
NOP_WORD, 16'hBF00, value driven on if_instruction when not valid

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
if_load_request  in  1  fetch request; held high until if_output_valid
if_address  in  ADDR_WIDTH  fetch halfword address
if_output_valid  out  1  fetch data valid, one-cycle pulse
if_instruction  out  DATA_WIDTH  fetched halfword
ls_request  in  1  load/store request; held high until ls_output_valid
ls_write_enable  in  1  1=store, 0=load; sampled at grant
ls_address  in  ADDR_WIDTH  load/store halfword address
ls_write_data  in  DATA_WIDTH  store data
ls_output_valid  out  1  load data valid or store done, one-cycle pulse
ls_read_data  out  DATA_WIDTH  load data
mem_request  out  1  request to memory
mem_write_enable  out  1  write strobe to memory
mem_address  out  ADDR_WIDTH  memory address
mem_write_data  out  DATA_WIDTH  memory write data
mem_read_data  in  DATA_WIDTH  memory read data
mem_output_valid  in  1  memory response/ack
busy  out  1  a transaction is outstanding
timeout_error  out  1  sticky; set on watchdog abort

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately, including mid-transaction):
  - state IDLE; last_served=LS; watchdog counter 0; all captured registers 0.
  - Outputs: mem_request=0, mem_write_enable=0, mem_address=0, mem_write_data=0, if_output_valid=0, ls_output_valid=0, if_instruction=NOP_WORD, ls_read_data=0, busy=0, timeout_error=0.
  - An aborted memory access is dropped; no valid pulse is produced afterwards.
- States: IDLE, SERVE_IF, SERVE_LS (2-bit encoding). Unused encoding goes to IDLE next cycle with all outputs at reset values.
- IDLE:
  - mem_request=0, busy=0.
  - Only if_load_request: go to SERVE_IF.
  - Only ls_request: go to SERVE_LS.
  - Both: grant the requester that is not last_served. After reset, IF wins the first tie.
  - On the grant edge, capture address, write data and write enable of the winner. IF captures write enable as 0.
- SERVE_x:
  - mem_request=1, busy=1.
  - mem_address, mem_write_data and mem_write_enable are driven only from the captured registers; requester inputs may change without effect.
  - Counter increments each cycle.
- Response path:
  - When mem_output_valid=1 in SERVE_x, x_output_valid=1 in the same cycle (combinational).
  - if_instruction=mem_read_data, or ls_read_data=mem_read_data for a load; ls_read_data=0 for a store.
  - Next state IDLE; last_served<=x; counter cleared.
  - Minimum latency request to valid: 2 cycles (IDLE grant cycle plus 1 memory cycle).
- Requester protocol: a requester deasserts its request in the cycle after its valid pulse. IDLE re-arbitrates from live inputs, so a request still held there is served again.
- mem_output_valid while in IDLE is ignored: no valid pulse, no state change.
- Outside a valid cycle: if_output_valid=0, if_instruction=NOP_WORD, ls_output_valid=0, ls_read_data=0.
- Watchdog: in SERVE_x, if the counter reaches TIMEOUT_CYCLES with no mem_output_valid:
  - go to IDLE; set timeout_error=1 (held until reset); no valid pulse.
  - last_served<=x, so a still-pending other requester wins next.
  - A mem_output_valid in the same cycle as the timeout takes priority; the transaction completes normally.
- Back-to-back: both requests held continuously are serviced strictly alternately IF, LS, IF, ... with one IDLE cycle between transactions.

Test Plan:
- Release reset, if_load_request=1, if_address=12'h010, memory answers 16'h4770 one cycle after mem_request → mem_address=12'h010, mem_write_enable=0; if_output_valid pulses once with if_instruction=16'h4770; back to IDLE.
- ls_request=1, ls_write_enable=1, ls_address=12'h3FF, ls_write_data=16'hA5A5; change ls_address to 12'h000 after the grant → memory sees 12'h3FF/A5A5 with mem_write_enable=1 throughout; ls_output_valid pulses with ls_read_data=0.
- Both requests asserted continuously from reset → grant order IF, LS, IF, LS; no grant to the same requester twice in a row.
- TIMEOUT_CYCLES=4, memory never answers an IF request, ls_request also pending → abort after 4 serve cycles; timeout_error=1 and stays 1; LS granted next; no if_output_valid.
- reset driven to 0 asynchronously mid-SERVE_LS, between clock edges → mem_request drops to 0 immediately, with no valid pulse; after release, a pending IF request is granted first.
- mem_output_valid pulsed while IDLE with no requests → no valid outputs, busy=0, state unchanged.
